// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and framing constants for the program loader
//   state_t         loader FSM states
//   HDR_BYTES       bytes in the little-endian word-count header
//   BYTES_PER_WORD  bytes assembled into one instruction word
package prog_loader_pkg;
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, FLUSH, CSUM, DONE, ERROR} state_t;
    localparam int HDR_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, control and program-memory write bundle of the loader
//   in_valid/in_byte/in_ready  byte handshake from the host source
//   start                      reload request pulse
//   mem_we/mem_addr/mem_wdata  program memory write port
//   cpu_reset/done/error       core hold and load status
//   master: host/memory side, slave: loader side
interface prog_loader_if #(parameter int ADDR_WIDTH = 8);
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic                  start;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;
    modport master (
        output in_valid, in_byte, start,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
    modport slave (
        input  in_valid, in_byte, start,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader_word_asm.sv
// prog_loader_word_asm: little-endian byte-to-word assembler with a one-cycle word_valid pulse
//   clk, reset      clock and synchronous active-low reset
//   byte_en_i       a data byte is accepted this cycle
//   byte_i          the accepted byte
//   byte_idx_o      lane the next byte lands in (0..3)
//   word_valid_o    high for one cycle after the 4th byte of a word
//   word_o          last completed word, held between completions
module prog_loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
    logic        valid_q;
    logic [31:0] word_q;
    logic        last;

    assign last = idx_q == 2'(BYTES_PER_WORD - 1);

    // The top byte never needs storing in asm_q: it goes straight into the output word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q   <= '0;
            asm_q   <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= byte_en_i && last;
            if (byte_en_i) begin
                idx_q <= idx_q + 2'd1;
                if (last) word_q <= {byte_i, asm_q};
                else asm_q[{idx_q, 3'b000} +: 8] <= byte_i;
            end
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_valid_o = valid_q;
    assign word_o       = word_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes program memory and holds the CPU until done
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    prog_loader_if.slave: byte handshake, start, memory write port, cpu_reset/done/error
// Build option PROG_LOADER_CHECKSUM_EN: a trailing XOR checksum byte gates DONE vs ERROR.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8 * HDR_BYTES
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);
    localparam logic [LEN_WIDTH-1:0] MAX_WORDS = LEN_WIDTH'(2 ** ADDR_WIDTH);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t DATA_NEXT  = CSUM;
    localparam state_t EMPTY_NEXT = CSUM;
`else
    localparam state_t DATA_NEXT  = FLUSH;
    localparam state_t EMPTY_NEXT = DONE;
`endif

    state_t                state_q, state_d;
    logic [7:0]            lo_q, lo_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif
    logic                  xfer;
    logic                  byte_en;
    logic                  word_end;
    logic                  last_word;
    logic [1:0]            byte_idx;
    logic [LEN_WIDTH-1:0]  hdr_len;

`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.in_ready = reset && (state_q inside {LEN_LO, LEN_HI, DATA, CSUM});
`else
    assign bus.in_ready = reset && (state_q inside {LEN_LO, LEN_HI, DATA});
`endif
    assign xfer      = bus.in_valid && bus.in_ready;
    assign byte_en   = xfer && state_q == DATA;
    assign word_end  = byte_en && byte_idx == 2'(BYTES_PER_WORD - 1);
    // cnt_q is one bit wider than the address so a full-capacity image never wraps.
    assign last_word = LEN_WIDTH'(cnt_q + 1'b1) == len_q;
    assign hdr_len   = LEN_WIDTH'({bus.in_byte, lo_q});

    prog_loader_word_asm u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_en_i    (byte_en),
        .byte_i       (bus.in_byte),
        .byte_idx_o   (byte_idx),
        .word_valid_o (bus.mem_we),
        .word_o       (bus.mem_wdata)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            LEN_LO: if (xfer) begin
                lo_d    = bus.in_byte;
                state_d = LEN_HI;
            end
            LEN_HI: if (xfer) begin
                len_d   = hdr_len;
                state_d = hdr_len == '0 ? EMPTY_NEXT : hdr_len > MAX_WORDS ? ERROR : DATA;
            end
            DATA: if (byte_en) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ bus.in_byte;
`endif
                // Address is latched alongside the word so it lines up with the write strobe.
                if (word_end) begin
                    addr_d = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d  = cnt_q + 1'b1;
                    if (last_word) state_d = DATA_NEXT;
                end
            end
            FLUSH: state_d = DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: if (xfer) state_d = bus.in_byte == csum_q ? DONE : ERROR;
`endif
            DONE, ERROR: if (bus.start) begin
                state_d = LEN_LO;
                lo_d    = '0;
                len_d   = '0;
                cnt_d   = '0;
                addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            default: state_d = LEN_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LEN_LO;
            lo_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.cpu_reset = state_q != DONE;
    assign bus.done      = state_q == DONE;
    assign bus.error     = state_q == ERROR;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader with a write scoreboard
module tb_prog_loader;
    logic clk = 1'b0;
    logic reset;
    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    logic [39:0] exp_q[$];
    logic [31:0] frame_q[$];

    prog_loader_if #(.ADDR_WIDTH(8)) bus ();

    prog_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_we === 1'b1) begin
                chk("we_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    chk("we_addr", 32'(bus.mem_addr), 32'(e[39:32]));
                    chk("we_data", bus.mem_wdata, e[31:0]);
                    chk("hold_during_we", 32'(bus.cpu_reset), 1);
                end
            end
            if (bus.done === 1'b1 || bus.error === 1'b1)
                chk("ready_when_idle", 32'(bus.in_ready), 0);
        end
    end

    task automatic send(input logic [7:0] b);
        int k;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) chk("send_ready_timeout", 32'(bus.in_ready), 1);
        @(negedge clk);
    endtask

    // Idle cycle; start is pulsed here to show it is ignored mid-load.
    task automatic idle();
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic load(input bit gap, input bit force_csum, input logic [7:0] forced);
        logic [15:0] n;
        logic [7:0] cs, b;
        n  = 16'(frame_q.size());
        cs = 8'h00;
        send(n[7:0]);
        if (gap) idle();
        send(n[15:8]);
        foreach (frame_q[i]) begin
            exp_q.push_back({8'(i), frame_q[i]});
            for (int j = 0; j < 4; j++) begin
                if (gap) idle();
                b  = frame_q[i][8*j +: 8];
                cs = cs ^ b;
                send(b);
            end
        end
        if (n != 0) begin
            chk("last_we", 32'(bus.mem_we), 1);
            chk("last_we_addr", 32'(bus.mem_addr), 32'(n - 1));
            chk("last_we_hold", 32'(bus.cpu_reset), 1);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(force_csum ? forced : cs);
`else
        if (force_csum) cs = forced;
        bus.in_valid = 1'b0;
        if (n != 0) @(negedge clk);
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 0);
        chk({tag, "_error"}, 32'(bus.error), 0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic restart();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_ready", 32'(bus.in_ready), 1);
        chk("restart_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("restart_done", 32'(bus.done), 0);
        chk("restart_error", 32'(bus.error), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_error"}, 32'(bus.error), 0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.start    = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check_reset_state("por");
        reset = 1'b1;
        @(negedge clk);
        chk("por_release_ready", 32'(bus.in_ready), 1);

        // Two-word image, back-to-back bytes.
        frame_q = '{32'h06400293, 32'h00C000EF};
        load(1'b0, 1'b0, 8'h00);
        expect_done("two_word");
        restart();

        // Same image with in_valid toggling every other cycle.
        load(1'b1, 1'b0, 8'h00);
        expect_done("gapped");
        restart();

        // Empty image.
        frame_q = {};
        load(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2 && bus.done !== 1'b1; i++) @(negedge clk);
        expect_done("empty");
        restart();

        // Oversized header (257 words) is rejected, then recovery.
        send(8'h01);
        send(8'h01);
        bus.in_valid = 1'b0;
        chk("oversize_error", 32'(bus.error), 1);
        chk("oversize_ready", 32'(bus.in_ready), 0);
        chk("oversize_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("oversize_done", 32'(bus.done), 0);
        restart();
        frame_q = '{32'hDEADBEEF};
        load(1'b0, 1'b0, 8'h00);
        expect_done("after_error");
        restart();

        // Full capacity: final write lands at address 0xFF.
        frame_q = {};
        for (int i = 0; i < 256; i++) frame_q.push_back((32'(i) * 32'h01010101) ^ 32'hA5C3_0F96);
        load(1'b0, 1'b0, 8'h00);
        expect_done("full");
        restart();

        // Reset dropped after 6 data bytes aborts the load.
        exp_q.push_back({8'h00, 32'h11223344});
        send(8'h02); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        send(8'h88); send(8'h77);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("abort_ready_low", 32'(bus.in_ready), 0);
        @(negedge clk);
        check_reset_state("abort");
        chk("abort_drained", 32'(exp_q.size()), 0);
        reset = 1'b1;
        @(negedge clk);
        frame_q = '{32'hCAFEF00D, 32'h0BADC0DE};
        load(1'b0, 1'b0, 8'h00);
        expect_done("after_abort");

`ifdef PROG_LOADER_CHECKSUM_EN
        restart();
        frame_q = '{32'h06400293};
        load(1'b0, 1'b0, 8'h00);
        expect_done("csum_good");
        restart();
        load(1'b0, 1'b1, 8'h00);
        chk("csum_bad_error", 32'(bus.error), 1);
        chk("csum_bad_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("csum_bad_done", 32'(bus.done), 0);
        chk("csum_bad_written", 32'(exp_q.size()), 0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
